sha256_avalon_stream_if: RTL and testbench
==========================================

# sha256_avalon_stream_if

Parametrised Avalon-MM slave front end for the SHA-256 hash cores. Buffers message words in an internal FIFO, streams them to the core over a valid/ready handshake, captures the multi-word digest on core completion, and exposes status, sticky error flags and a level interrupt to the Nios II. Sits between the Avalon bus and any hash core with a start/stream/done interface.

## Interface
- DATA_W, 32, bus and message word width
- ADDR_W, 5, Avalon word address width
- DIGEST_WORDS, 8, digest length in DATA_W words; the map must satisfy 3+DIGEST_WORDS <= 2^ADDR_W
- FIFO_DEPTH, 16, message FIFO entries; power of 2, >= 2
- iClk  in  1  clock
- iReset_n  in  1  reset, asynchronous, active-low
- iChipselect_n  in  1  slave select, active-low
- iWrite_n  in  1  write strobe, active-low
- iRead_n  in  1  read strobe, active-low
- iAddress  in  ADDR_W  word address
- iData  in  DATA_W  write data
- oData  out  DATA_W  registered read data
- oIrq  out  1  interrupt, level, = IRQ_EN & DONE
- oCoreStart  out  1  one-cycle start pulse to core
- oCoreData  out  DATA_W  FIFO head word
- oCoreValid  out  1  oCoreData valid
- iCoreReady  in  1  core accepts word
- iCoreDone  in  1  digest valid pulse from core
- iCoreDigest  in  DATA_W*DIGEST_WORDS  digest, word 0 in MS bits

## Operation
- Register map, write = !iChipselect_n & !iWrite_n, read = !iChipselect_n & !iRead_n:
  - 0x00 CTRL: bit0 START (self-clearing, reads 0), bit1 IRQ_EN, bit2 FLUSH (self-clearing, reads 0)
  - 0x01 DATA (write-only, reads 0): push iData into FIFO
  - 0x02 STATUS: bit0 DONE (sticky, W1C), bit1 BUSY, bit2 OVF (sticky, W1C), bit3 EMPTY, bit4 FULL, bits[15:8] FIFO count; other bits 0
  - 0x03 .. 0x03+DIGEST_WORDS-1: digest words, word 0 (MS) at 0x03
  - any other address reads 0; writes ignored
- FSM states IDLE, RUN:
  - IDLE: START write -> oCoreStart=1 next cycle, DONE cleared, state RUN
  - RUN: oCoreValid = !EMPTY; pop when oCoreValid & iCoreReady; iCoreDone -> latch iCoreDigest into digest regs, DONE=1, state IDLE
  - START write in RUN ignored; iCoreDone in IDLE ignored (digest unchanged)
  - BUSY = (state == RUN); oCoreValid = 0 in IDLE
- FIFO: count width $clog2(FIFO_DEPTH+1); pointers wrap mod FIFO_DEPTH
  - push accepted if count < FIFO_DEPTH, or a pop occurs in the same cycle
  - push otherwise dropped, OVF set, FIFO unchanged
  - simultaneous push and pop: count unchanged, both take effect
  - FLUSH: pointers and count zeroed; FSM state unaffected; no pop that cycle
- Priority: iCoreDone set of DONE beats a same-cycle W1C clear; overflow set beats a same-cycle OVF clear.
- Reset: all outputs 0, CTRL/STATUS/digest/FIFO pointers 0, state IDLE. Reset mid-RUN aborts silently; the core is reset by the same signal.

## Timing
- Read latency 1: oData valid the cycle after the read strobe; holds last value when not read.
- Register writes take effect on the clock edge of the strobe; STATUS reflects them on the next read.
- START write at edge N -> oCoreStart high N+1..N+2 (one cycle), BUSY=1 from N+1.
- DATA write at edge N -> word visible on oCoreData (in RUN, FIFO was empty) from N+1.
- iCoreDone at edge N -> digest, DONE and oIrq updated at N+1; state IDLE at N+1.
- Throughput: one word per cycle when iCoreReady held high and FIFO non-empty.

## Test plan
- Reset: assert iReset_n=0 mid-RUN with 5 words queued -> all outputs 0, STATUS read = 0x00000008 (EMPTY).
- Basic hash: push 16 words 0x61626380,0,...,0x18; START; core ready=1; iCoreDone with digest ba7816bf...f20015ad -> 0x03 reads 0xba7816bf, 0x0A reads 0xf20015ad, STATUS bit0=1, BUSY=0.
- Overflow: iCoreReady=0, push FIFO_DEPTH+1 words -> FULL=1, OVF=1, count=16; write STATUS 0x4 -> OVF=0; push while pop same cycle when full -> accepted, no OVF.
- Backpressure: toggle iCoreReady 1/0 each cycle -> every word popped exactly once, in order, none duplicated.
- IRQ and W1C race: IRQ_EN=1, iCoreDone coinciding with STATUS write 0x1 -> DONE stays 1, oIrq=1; later clear -> oIrq=0.
- Flush and ignored events: FLUSH with 7 words queued in RUN -> count=0, BUSY=1; START during RUN -> no oCoreStart pulse; iCoreDone in IDLE -> digest unchanged.

Source files
------------

// File: rtl/sha256_avalon_stream_if.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_avalon_stream_if
//  Purpose  : Avalon-MM slave front end for a streaming hash core. Message
//             words written to DATA are queued in a FIFO and streamed to the
//             core over valid/ready. The digest is captured when the core
//             signals completion. Status, sticky error flags and a level
//             interrupt are exposed to the host.
//  Ports    : iClk, iReset_n (async, active-low)
//             Avalon slave : iChipselect_n, iWrite_n, iRead_n, iAddress,
//                            iData, oData (registered, 1-cycle latency), oIrq
//             Core side    : oCoreStart, oCoreData, oCoreValid, iCoreReady,
//                            iCoreDone, iCoreDigest (word 0 in MS bits)
//  Map      : 0x00 CTRL   bit0 START(sc) bit1 IRQ_EN bit2 FLUSH(sc)
//             0x01 DATA   write-only FIFO push
//             0x02 STATUS bit0 DONE(W1C) bit1 BUSY bit2 OVF(W1C) bit3 EMPTY
//                         bit4 FULL bits[15:8] FIFO count
//             0x03..      digest words, word 0 first
//  Revision : 1.0 - initial release
// ============================================================================
module sha256_avalon_stream_if #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int DIGEST_WORDS = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                           iClk,
    input  logic                           iReset_n,
    input  logic                           iChipselect_n,
    input  logic                           iWrite_n,
    input  logic                           iRead_n,
    input  logic [ADDR_W-1:0]              iAddress,
    input  logic [DATA_W-1:0]              iData,
    output logic [DATA_W-1:0]              oData,
    output logic                           oIrq,
    output logic                           oCoreStart,
    output logic [DATA_W-1:0]              oCoreData,
    output logic                           oCoreValid,
    input  logic                           iCoreReady,
    input  logic                           iCoreDone,
    input  logic [DATA_W*DIGEST_WORDS-1:0] iCoreDigest
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic bus_wr;
    logic bus_rd;
    logic ctrl_wr;
    logic data_wr;
    logic status_wr;
    logic start_req;
    logic flush_req;

    assign bus_wr    = !iChipselect_n && !iWrite_n;
    assign bus_rd    = !iChipselect_n && !iRead_n;
    assign ctrl_wr   = bus_wr && (iAddress == ADDR_W'(0));
    assign data_wr   = bus_wr && (iAddress == ADDR_W'(1));
    assign status_wr = bus_wr && (iAddress == ADDR_W'(2));
    assign start_req = ctrl_wr && iData[0];
    assign flush_req = ctrl_wr && iData[2];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    logic start_go;
    logic core_fin;

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_go   = 1'b0;
        core_fin   = 1'b0;
        case (state)
            IDLE: begin
                if (start_req) begin
                    start_go   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (iCoreDone) begin
                    core_fin   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Message FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic              push_ok;
    logic              push_drop;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign oCoreValid = (state == RUN) && !fifo_empty;
    // A flush discards everything, including any word that would have been
    // handed to the core or written by a same-cycle DATA access.
    assign pop        = oCoreValid && iCoreReady && !flush_req;
    assign push_ok    = data_wr && !flush_req && (!fifo_full || pop);
    assign push_drop  = data_wr && !flush_req && fifo_full && !pop;
    // Gated so the core port reads zero while nothing is queued.
    assign oCoreData  = fifo_empty ? '0 : mem[rd_ptr];

    always_ff @(posedge iClk) begin
        if (push_ok) begin
            mem[wr_ptr] <= iData;
        end
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_req) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control / status registers and digest capture
    // ------------------------------------------------------------------
    logic              irq_en;
    logic              done;
    logic              ovf;
    logic [DATA_W-1:0] digest [DIGEST_WORDS];

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            irq_en     <= 1'b0;
            done       <= 1'b0;
            ovf        <= 1'b0;
            oCoreStart <= 1'b0;
            for (int i = 0; i < DIGEST_WORDS; i++) begin
                digest[i] <= '0;
            end
        end else begin
            oCoreStart <= start_go;
            if (ctrl_wr) begin
                irq_en <= iData[1];
            end
            // Completion set wins over a same-cycle W1C clear.
            if (core_fin) begin
                done <= 1'b1;
            end else if (start_go || (status_wr && iData[0])) begin
                done <= 1'b0;
            end
            if (push_drop) begin
                ovf <= 1'b1;
            end else if (status_wr && iData[2]) begin
                ovf <= 1'b0;
            end
            if (core_fin) begin
                for (int i = 0; i < DIGEST_WORDS; i++) begin
                    digest[i] <= iCoreDigest[DATA_W*(DIGEST_WORDS-i)-1 -: DATA_W];
                end
            end
        end
    end

    assign oIrq = irq_en && done;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] status_word;
    logic [DATA_W-1:0] rd_mux;

    always_comb begin
        status_word       = '0;
        status_word[0]    = done;
        status_word[1]    = (state == RUN);
        status_word[2]    = ovf;
        status_word[3]    = fifo_empty;
        status_word[4]    = fifo_full;
        status_word[15:8] = 8'(count);
    end

    always_comb begin
        rd_mux = '0;
        if (iAddress == ADDR_W'(0)) begin
            rd_mux[1] = irq_en;
        end else if (iAddress == ADDR_W'(2)) begin
            rd_mux = status_word;
        end else begin
            for (int i = 0; i < DIGEST_WORDS; i++) begin
                if (iAddress == ADDR_W'(3 + i)) begin
                    rd_mux = digest[i];
                end
            end
        end
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            oData <= '0;
        end else if (bus_rd) begin
            oData <= rd_mux;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha256_avalon_stream_if.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sha256_avalon_stream_if
//  Purpose  : Directed self-checking bench for sha256_avalon_stream_if.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_avalon_stream_if;

    logic         iClk = 1'b0;
    logic         iReset_n;
    logic         iChipselect_n;
    logic         iWrite_n;
    logic         iRead_n;
    logic [4:0]   iAddress;
    logic [31:0]  iData;
    logic [31:0]  oData;
    logic         oIrq;
    logic         oCoreStart;
    logic [31:0]  oCoreData;
    logic         oCoreValid;
    logic         iCoreReady;
    logic         iCoreDone;
    logic [255:0] iCoreDigest;

    int checks   = 0;
    int failures = 0;
    int start_cnt = 0;
    logic [31:0] popped [$];

    always #5 iClk = ~iClk;

    sha256_avalon_stream_if #(
        .DATA_W       (32),
        .ADDR_W       (5),
        .DIGEST_WORDS (8),
        .FIFO_DEPTH   (16)
    ) dut (
        .iClk          (iClk),
        .iReset_n      (iReset_n),
        .iChipselect_n (iChipselect_n),
        .iWrite_n      (iWrite_n),
        .iRead_n       (iRead_n),
        .iAddress      (iAddress),
        .iData         (iData),
        .oData         (oData),
        .oIrq          (oIrq),
        .oCoreStart    (oCoreStart),
        .oCoreData     (oCoreData),
        .oCoreValid    (oCoreValid),
        .iCoreReady    (iCoreReady),
        .iCoreDone     (iCoreDone),
        .iCoreDigest   (iCoreDigest)
    );

    // Inputs change 1 time unit after a rising edge, so values seen at the
    // falling edge are the ones the next rising edge acts on.
    always @(negedge iClk) begin
        if (oCoreStart) start_cnt++;
        if (oCoreValid && iCoreReady) popped.push_back(oCoreData);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(posedge iClk); #1;
        iChipselect_n = 1'b0; iWrite_n = 1'b0; iAddress = a; iData = d;
        @(posedge iClk); #1;
        iChipselect_n = 1'b1; iWrite_n = 1'b1;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        @(posedge iClk); #1;
        iChipselect_n = 1'b0; iRead_n = 1'b0; iAddress = a;
        @(posedge iClk); #1;
        iChipselect_n = 1'b1; iRead_n = 1'b1;
        d = oData;
    endtask

    task automatic core_done(input logic [255:0] dg);
        @(posedge iClk); #1;
        iCoreDigest = dg; iCoreDone = 1'b1;
        @(posedge iClk); #1;
        iCoreDone = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge iClk); #1;
        end
    endtask

    localparam logic [255:0] DG_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DG_2   = 256'hd2000000_d2000001_d2000002_d2000003_d2000004_d2000005_d2000006_d2000007;
    localparam logic [255:0] DG_3   = 256'h30000000_31111111_32222222_33333333_34444444_35555555_36666666_37777777;
    localparam logic [255:0] DG_4   = {8{32'hdeadbeef}};

    initial begin
        logic [31:0] rd;
        int mism;

        iReset_n = 1'b0; iChipselect_n = 1'b1; iWrite_n = 1'b1; iRead_n = 1'b1;
        iAddress = '0; iData = '0; iCoreReady = 1'b0; iCoreDone = 1'b0;
        iCoreDigest = '0;
        idle_cycles(3);
        iReset_n = 1'b1;

        // ---- reset state
        check("reset_outputs", {29'd0, oIrq, oCoreStart, oCoreValid}, 32'd0);
        check("reset_coredata", oCoreData, 32'd0);
        bus_read(5'd2, rd);
        check("reset_status", rd, 32'h0000_0008);

        // ---- basic hash of "abc"
        for (int i = 0; i < 16; i++) begin
            bus_write(5'd1, (i == 0) ? 32'h61626380 : ((i == 15) ? 32'h18 : 32'h0));
        end
        bus_read(5'd2, rd);
        check("full_status", rd, 32'h0000_1010);
        start_cnt = 0;
        popped.delete();
        bus_write(5'd0, 32'h1);
        iCoreReady = 1'b1;
        for (int i = 0; i < 100 && oCoreValid; i++) begin
            @(posedge iClk); #1;
        end
        iCoreReady = 1'b0;
        check("basic_pop_count", 32'(popped.size()), 32'd16);
        check("basic_first_word", (popped.size() > 0) ? popped[0] : 32'hx, 32'h61626380);
        check("basic_last_word", (popped.size() > 15) ? popped[15] : 32'hx, 32'h18);
        check("start_pulse_once", 32'(start_cnt), 32'd1);
        bus_read(5'd2, rd);
        check("busy_status", rd, 32'h0000_000A);
        core_done(DG_ABC);
        bus_read(5'd3, rd);
        check("digest_w0", rd, 32'hba7816bf);
        bus_read(5'd6, rd);
        check("digest_w3", rd, 32'h5dae2223);
        bus_read(5'd10, rd);
        check("digest_w7", rd, 32'hf20015ad);
        bus_read(5'd2, rd);
        check("done_status", rd, 32'h0000_0009);
        check("irq_disabled", {31'd0, oIrq}, 32'd0);

        // ---- overflow
        for (int i = 0; i < 17; i++) begin
            bus_write(5'd1, 32'h100 + i);
        end
        bus_read(5'd2, rd);
        check("ovf_status", rd, 32'h0000_1015);
        bus_write(5'd2, 32'h4);
        bus_read(5'd2, rd);
        check("ovf_cleared", rd, 32'h0000_1011);
        bus_write(5'd0, 32'h1);
        popped.delete();
        // Push into a full FIFO while the core pops in the same cycle.
        @(posedge iClk); #1;
        iChipselect_n = 1'b0; iWrite_n = 1'b0; iAddress = 5'd1; iData = 32'h200;
        iCoreReady = 1'b1;
        @(posedge iClk); #1;
        iChipselect_n = 1'b1; iWrite_n = 1'b1; iCoreReady = 1'b0;
        bus_read(5'd2, rd);
        check("push_pop_full", rd, 32'h0000_1012);
        check("push_pop_popped", (popped.size() == 1) ? popped[0] : 32'hx, 32'h100);

        // ---- backpressure drain
        popped.delete();
        for (int i = 0; i < 100 && oCoreValid; i++) begin
            @(posedge iClk); #1;
            iCoreReady = ~iCoreReady;
        end
        iCoreReady = 1'b0;
        check("bp_pop_count", 32'(popped.size()), 32'd16);
        mism = 0;
        for (int i = 0; i < 16 && i < popped.size(); i++) begin
            if (popped[i] !== ((i == 15) ? 32'h200 : 32'h101 + i)) mism++;
        end
        check("bp_order", 32'(mism), 32'd0);

        // ---- IRQ and W1C race
        bus_write(5'd0, 32'h2);
        @(posedge iClk); #1;
        iChipselect_n = 1'b0; iWrite_n = 1'b0; iAddress = 5'd2; iData = 32'h1;
        iCoreDigest = DG_2; iCoreDone = 1'b1;
        @(posedge iClk); #1;
        iChipselect_n = 1'b1; iWrite_n = 1'b1; iCoreDone = 1'b0;
        check("irq_after_race", {31'd0, oIrq}, 32'd1);
        bus_read(5'd2, rd);
        check("race_status", rd, 32'h0000_0009);
        bus_read(5'd3, rd);
        check("race_digest", rd, 32'hd2000000);
        bus_write(5'd2, 32'h1);
        check("irq_cleared", {31'd0, oIrq}, 32'd0);

        // ---- flush and ignored events
        start_cnt = 0;
        bus_write(5'd0, 32'h3);
        idle_cycles(2);
        check("start_pulse_f", 32'(start_cnt), 32'd1);
        for (int i = 0; i < 7; i++) begin
            bus_write(5'd1, 32'h300 + i);
        end
        check("head_word", oCoreData, 32'h300);
        bus_read(5'd2, rd);
        check("seven_queued", rd, 32'h0000_0702);
        bus_write(5'd0, 32'h6);
        bus_read(5'd2, rd);
        check("flush_status", rd, 32'h0000_000A);
        start_cnt = 0;
        bus_write(5'd0, 32'h3);
        idle_cycles(3);
        check("start_in_run", 32'(start_cnt), 32'd0);
        core_done(DG_3);
        bus_read(5'd3, rd);
        check("digest3_w0", rd, 32'h30000000);
        core_done(DG_4);
        bus_read(5'd3, rd);
        check("idle_done_w0", rd, 32'h30000000);
        bus_read(5'd10, rd);
        check("idle_done_w7", rd, 32'h37777777);

        // ---- reset mid-RUN with 5 words queued
        bus_write(5'd0, 32'h1);
        for (int i = 0; i < 5; i++) begin
            bus_write(5'd1, 32'h400 + i);
        end
        check("valid_before_rst", {31'd0, oCoreValid}, 32'd1);
        @(posedge iClk); #1;
        iReset_n = 1'b0;
        #2;
        check("rst_flags", {29'd0, oIrq, oCoreStart, oCoreValid}, 32'd0);
        check("rst_odata", oData, 32'd0);
        check("rst_coredata", oCoreData, 32'd0);
        @(posedge iClk); #1;
        iReset_n = 1'b1;
        bus_read(5'd2, rd);
        check("rst_status", rd, 32'h0000_0008);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
